// File: rtl/alu_writeback_register.sv
// alu_writeback_register
//
// Writeback stage behind the DE1-SoC ALU wrapper. It holds the architectural
// destination and flag registers, which feed back into the ALU as InDest and
// InFlags. A debounced press on the commit key captures the ALU result and
// flags. A debounced press on the load key loads Dest from the switches and
// clears Flags.
//
// Ports
//   clk_i           system clock (CLOCK_50)
//   rst_ni          asynchronous active-low reset
//   commit_key_ni   raw active-low push button; a press commits ALU result/flags
//   load_key_ni     raw active-low push button; a press loads load_value_i
//   load_value_i    value written to Dest by a load press (switches)
//   alu_result_i    ALU OutDest; combinationally depends on dest_o
//   alu_flags_i     ALU OutFlags
//   dest_o          registered destination value
//   flags_o         registered flags
//   commit_pulse_o  high for the single cycle after each accepted action
//   busy_o          high whenever the debounce FSM is not idle
//
// DebounceCycles must be at least 1.

module alu_writeback_register #(
   parameter int unsigned DataWidth      = 4,
   parameter int unsigned FlagWidth      = 5,
   parameter int unsigned DebounceCycles = 500000
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 commit_key_ni,
   input  logic                 load_key_ni,
   input  logic [DataWidth-1:0] load_value_i,
   input  logic [DataWidth-1:0] alu_result_i,
   input  logic [FlagWidth-1:0] alu_flags_i,
   output logic [DataWidth-1:0] dest_o,
   output logic [FlagWidth-1:0] flags_o,
   output logic                 commit_pulse_o,
   output logic                 busy_o
);

   localparam int unsigned CntWidth = $clog2(DebounceCycles + 1);
   localparam logic [CntWidth-1:0] CntLast = CntWidth'(DebounceCycles - 1);

   typedef enum logic [1:0] {
      StIdle,
      StPressDb,
      StHeld,
      StRelDb
   } state_e;

   typedef enum logic {
      PendCommit,
      PendLoad
   } pend_e;

   // Two-flop synchronisers; preset to 1 so reset looks like "key released".
   logic [1:0] commit_sync_q;
   logic [1:0] load_sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         commit_sync_q <= 2'b11;
         load_sync_q   <= 2'b11;
      end else begin
         commit_sync_q <= {commit_sync_q[0], commit_key_ni};
         load_sync_q   <= {load_sync_q[0], load_key_ni};
      end
   end

   logic s_commit;
   logic s_load;
   assign s_commit = commit_sync_q[1];
   assign s_load   = load_sync_q[1];

   state_e                state_q;
   pend_e                 pending_q;
   logic [CntWidth-1:0]   cnt_q;
   logic [DataWidth-1:0]  dest_q;
   logic [FlagWidth-1:0]  flags_q;
   logic                  commit_pulse_q;
   logic                  busy_q;
   // A key is armed once seen released. Any key seen low while busy is disarmed,
   // so a key held across another key's action cannot fire until it is
   // released and pressed again.
   logic                  commit_armed_q;
   logic                  load_armed_q;

   logic pend_key;
   assign pend_key = (pending_q == PendLoad) ? s_load : s_commit;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= StIdle;
         pending_q      <= PendCommit;
         cnt_q          <= '0;
         dest_q         <= '0;
         flags_q        <= '0;
         commit_pulse_q <= 1'b0;
         busy_q         <= 1'b0;
         commit_armed_q <= 1'b1;
         load_armed_q   <= 1'b1;
      end else begin
         commit_pulse_q <= 1'b0;
         commit_armed_q <= s_commit | (commit_armed_q & (state_q == StIdle));
         load_armed_q   <= s_load | (load_armed_q & (state_q == StIdle));

         unique case (state_q)
            StIdle: begin
               // Commit wins when both keys go low together.
               if (!s_commit && commit_armed_q) begin
                  pending_q <= PendCommit;
                  cnt_q     <= '0;
                  state_q   <= StPressDb;
                  busy_q    <= 1'b1;
               end else if (!s_load && load_armed_q) begin
                  pending_q <= PendLoad;
                  cnt_q     <= '0;
                  state_q   <= StPressDb;
                  busy_q    <= 1'b1;
               end
            end

            StPressDb: begin
               if (pend_key) begin
                  // Released before the press was stable: glitch, no action.
                  cnt_q   <= '0;
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else if (cnt_q == CntLast) begin
                  if (pending_q == PendLoad) begin
                     dest_q  <= load_value_i;
                     flags_q <= '0;
                  end else begin
                     dest_q  <= alu_result_i;
                     flags_q <= alu_flags_i;
                  end
                  commit_pulse_q <= 1'b1;
                  state_q        <= StHeld;
               end else begin
                  cnt_q <= cnt_q + CntWidth'(1);
               end
            end

            StHeld: begin
               if (pend_key) begin
                  cnt_q   <= '0;
                  state_q <= StRelDb;
               end
            end

            StRelDb: begin
               if (!pend_key) begin
                  // Release bounced; wait for a clean release again.
                  state_q <= StHeld;
               end else if (cnt_q == CntLast) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CntWidth'(1);
               end
            end

            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign dest_o         = dest_q;
   assign flags_o        = flags_q;
   assign commit_pulse_o = commit_pulse_q;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_alu_writeback_register.sv
module tb_alu_writeback_register;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       commit_key_n = 1'b1;
   logic       load_key_n = 1'b1;
   logic [3:0] load_value = '0;
   logic [3:0] src = '0;
   logic [4:0] alu_flags = '0;
   logic [3:0] alu_result;
   logic [3:0] dest;
   logic [4:0] flags;
   logic       commit_pulse;
   logic       busy;

   // Behavioural ALU: ADD of src into the fed-back Dest.
   assign alu_result = dest + src;

   alu_writeback_register #(
      .DataWidth      (4),
      .FlagWidth      (5),
      .DebounceCycles (D)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .commit_key_ni  (commit_key_n),
      .load_key_ni    (load_key_n),
      .load_value_i   (load_value),
      .alu_result_i   (alu_result),
      .alu_flags_i    (alu_flags),
      .dest_o         (dest),
      .flags_o        (flags),
      .commit_pulse_o (commit_pulse),
      .busy_o         (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0] dest;
      logic [4:0] flags;
      int         cyc;
   } exp_t;

   exp_t sb_q[$];
   int errors = 0;
   int checks = 0;

   // Architectural model of the register contents.
   logic [3:0] dest_m = '0;
   logic [4:0] flags_m = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: every action pulse must match the oldest expected action.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && commit_pulse) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse at cycle %0d: dest=%0h flags=%0h, expected no action",
                     cyc, dest, flags);
         end else begin
            e = sb_q.pop_front();
            check("pulse_cycle", cyc, e.cyc);
            check("action_dest", dest, e.dest);
            check("action_flags", flags, e.flags);
         end
      end
   end

   // Called right after a negedge. Drive one key for 'hold' cycles, then
   // release for 'gap' cycles. An action is expected iff the key is seen low
   // for at least D+1 consecutive sampling edges.
   task automatic press(input bit is_load, input int hold, input int gap,
                        input logic [3:0] v, input logic [4:0] f);
      exp_t e;
      if (is_load) load_value = v;
      else begin
         src       = v;
         alu_flags = f;
      end
      if (hold >= D + 1) begin
         e.cyc = cyc + D + 3;
         if (is_load) begin
            e.dest  = v;
            e.flags = '0;
         end else begin
            e.dest  = dest_m + v;
            e.flags = f;
         end
         dest_m  = e.dest;
         flags_m = e.flags;
         sb_q.push_back(e);
      end
      if (is_load) load_key_n = 1'b0;
      else commit_key_n = 1'b0;
      repeat (hold) @(negedge clk);
      load_key_n   = 1'b1;
      commit_key_n = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin : stim
      int   k;
      exp_t e;
      logic [4:0] f;
      logic [3:0] s;

      // Reset state.
      #1;
      check("reset_dest", dest, 0);
      check("reset_flags", flags, 0);
      check("reset_busy", busy, 0);
      check("reset_pulse", commit_pulse, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_dest", dest, 0);
         check("idle_flags", flags, 0);
         check("idle_busy", busy, 0);
         check("idle_pulse", commit_pulse, 0);
      end

      // Load 5 with key held: action at edge D+3, Dest stays while held.
      k = cyc;
      load_value = 4'h5;
      e.dest = 4'h5; e.flags = '0; e.cyc = k + D + 3;
      sb_q.push_back(e);
      dest_m = 4'h5; flags_m = '0;
      load_key_n = 1'b0;
      repeat (D + 2) @(negedge clk);
      check("load_before_action", dest, 0);
      @(negedge clk);
      check("load_dest", dest, 5);
      repeat (3) @(negedge clk);
      check("load_held_dest", dest, 5);
      check("load_held_busy", busy, 1);
      check("load_held_pulse", commit_pulse, 0);
      load_key_n = 1'b1;
      repeat (D + 6) @(negedge clk);

      // Commit 9 / 00110, held 10 cycles, then check release timing of busy.
      k = cyc;
      src = 4'(4'h9 - dest_m);
      alu_flags = 5'b00110;
      e.dest = 4'h9; e.flags = 5'b00110; e.cyc = k + D + 3;
      sb_q.push_back(e);
      dest_m = 4'h9; flags_m = 5'b00110;
      commit_key_n = 1'b0;
      repeat (10) @(negedge clk);
      commit_key_n = 1'b1;
      repeat (D + 2) @(negedge clk);
      check("busy_before_release_done", busy, 1);
      @(negedge clk);
      check("busy_after_release_done", busy, 0);
      check("commit_dest", dest, 9);
      check("commit_flags", flags, 5'b00110);
      repeat (D) @(negedge clk);

      // Bounce: low 2, high 1, low 2 -> no action.
      src = 4'h3;
      commit_key_n = 1'b0; repeat (2) @(negedge clk);
      commit_key_n = 1'b1; @(negedge clk);
      commit_key_n = 1'b0; repeat (2) @(negedge clk);
      commit_key_n = 1'b1;
      repeat (D + 6) @(negedge clk);
      check("bounce_dest", dest, dest_m);
      check("bounce_busy", busy, 0);

      // Hold-length boundary: D samples reject, D+1 samples accept.
      press(1'b0, D, D + 6, 4'h2, 5'h11);
      check("short_press_dest", dest, dest_m);
      press(1'b0, D + 1, D + 6, 4'h2, 5'h11);
      check("min_press_dest", dest, dest_m);

      // Both keys together: commit wins, held load is then ignored.
      f = 5'($urandom);
      k = cyc;
      load_value = 4'h3;
      src = 4'(4'h7 - dest_m);
      alu_flags = f;
      e.dest = 4'h7; e.flags = f; e.cyc = k + D + 3;
      sb_q.push_back(e);
      dest_m = 4'h7; flags_m = f;
      commit_key_n = 1'b0;
      load_key_n = 1'b0;
      repeat (D + 3) @(negedge clk);
      commit_key_n = 1'b1;
      repeat (3 * D + 10) @(negedge clk);
      check("both_dest", dest, 7);
      check("both_load_ignored_busy", busy, 0);
      load_key_n = 1'b1;
      repeat (D + 4) @(negedge clk);
      press(1'b1, D + 3, D + 6, 4'h3, 5'h0);
      check("fresh_load_dest", dest, 3);

      // Reset mid-debounce with Dest = 5, key held through reset release.
      press(1'b1, D + 3, D + 6, 4'h5, 5'h0);
      s = 4'($urandom_range(1, 15));
      f = 5'($urandom);
      src = s;
      alu_flags = f;
      commit_key_n = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_dest", dest, 0);
      check("midreset_flags", flags, 0);
      check("midreset_busy", busy, 0);
      sb_q.delete();
      dest_m = '0; flags_m = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      k = cyc;
      e.dest = s; e.flags = f; e.cyc = k + D + 3;
      sb_q.push_back(e);
      dest_m = s; flags_m = f;
      repeat (D + 5) @(negedge clk);
      check("post_reset_dest", dest, s);
      commit_key_n = 1'b1;
      repeat (D + 6) @(negedge clk);

      // Randomised accumulate / load sequence.
      for (int i = 0; i < 24; i++) begin
         press(($urandom % 3) == 0, $urandom_range(1, D + 6), $urandom_range(D + 4, D + 10),
               4'($urandom), 5'($urandom));
         check("rand_dest", dest, dest_m);
         check("rand_flags", flags, flags_m);
         check("rand_busy", busy, 0);
      end

      repeat (4) @(negedge clk);
      check("scoreboard_empty", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_writeback_register.md
Name: alu_writeback_register

Overview:
- Downstream stage of the DE1-SoC ALU wrapper. It holds the architectural destination register and flag register, and captures the ALU result and flags when a debounced key press occurs.
- Its Dest and Flags outputs feed back as the ALU InDest and InFlags. Repeated presses therefore accumulate results; for example, pressing commit with an ADD operation selected adds Src into Dest again on each press.
- A second key loads Dest directly from the switches so the register can be initialised.

Parameters:
- DataWidth, 4, width of the destination register and ALU result; must match InstructionSetPkg DataWidth.
- FlagWidth, 5, width of the flag register and ALU OutFlags.
- DebounceCycles, 500000, number of consecutive stable synchronised samples required to accept a press or release (10 ms at 50 MHz); minimum value 1.

Ports:
- Clock, input, 1, system clock (CLOCK_50).
- nReset, input, 1, asynchronous active-low reset.
- nCommitKey, input, 1, raw active-low push button, asynchronous to Clock; a press writes the ALU result and flags.
- nLoadKey, input, 1, raw active-low push button, asynchronous to Clock; a press writes LoadValue.
- LoadValue, input, DataWidth, value loaded into Dest by a load press (switches).
- AluResult, input, DataWidth, ALU OutDest.
- AluFlags, input, FlagWidth, ALU OutFlags.
- Dest, output, DataWidth, registered destination value (drives ALU InDest and the display).
- Flags, output, FlagWidth, registered flags (drive ALU InFlags and LEDR).
- CommitPulse, output, 1, high for exactly one cycle after each accepted action (commit or load).
- Busy, output, 1, high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, nReset low):
  - Dest = 0, Flags = 0, CommitPulse = 0, Busy = 0.
  - FSM = IDLE, debounce counter = 0, Pending = COMMIT.
  - Both two-flop synchronisers preset to 1 (key released).
- Input synchronisation: each key passes through a two-flop synchroniser. Only the synchronised values (sCommit, sLoad; active-low) are used after that point.
- FSM states:
  - IDLE:
    - If sCommit = 0, set Pending = COMMIT and go to PRESS_DB. Commit has priority when both keys are low.
    - Else if sLoad = 0, set Pending = LOAD and go to PRESS_DB.
    - Counter is cleared on entry to PRESS_DB.
  - PRESS_DB:
    - The pending key's synchronised value is sampled every cycle.
    - If it is 1 (released), go to IDLE and clear the counter (glitch rejected, no action).
    - Else if counter = DebounceCycles-1, perform the action on this edge and go to HELD.
    - Else increment the counter.
  - HELD:
    - While the pending key is 0, stay in HELD.
    - When it is 1, clear the counter and go to REL_DB.
  - REL_DB:
    - If the pending key is 0 (bounce), go to HELD.
    - Else if counter = DebounceCycles-1, go to IDLE.
    - Else increment the counter.
- Actions are registered on one edge:
  - COMMIT: Dest <= AluResult and Flags <= AluFlags, both sampled on the action edge.
  - LOAD: Dest <= LoadValue and Flags <= 0.
  - In both cases CommitPulse = 1 for the following cycle only.
- Latency: with a key held low continuously from the edge where it is first sampled (edge 1), the action edge is edge DebounceCycles+3. New Dest/Flags and CommitPulse are visible after that edge.
- Exclusivity:
  - While Busy = 1, the non-pending key is ignored completely.
  - A key held through the action never repeats; one press gives exactly one action.
  - A new action requires a debounced release followed by a fresh press.
- Combinational feedback loop: AluResult depends combinationally on Dest. Dest changes only on the action edge, so the loop is broken by the register.
- Counter: unsigned, $clog2(DebounceCycles+1) bits. It never wraps because it is bounded by the compare.
- Reset mid-debounce or mid-HELD: the FSM returns to IDLE and Dest/Flags are cleared. A key still held at reset release is treated as a new press and produces an action after a full debounce.

Test Plan (DebounceCycles = 4, DataWidth = 4):
- Reset release, keys high for 20 cycles -> Dest=0, Flags=0, CommitPulse never high, Busy=0.
- LoadValue=4'h5, nLoadKey low from edge 1 and held -> Dest=5 and Flags=0 after edge 7. CommitPulse is high only for the cycle after edge 7. Dest stays 5 while the key remains held.
- AluResult=4'h9, AluFlags=5'b00110, nCommitKey held low 10 cycles then released -> Dest=9, Flags=00110 after edge 7. Busy falls 6 cycles after release is first sampled (2 synchroniser cycles plus 4 debounce cycles).
- nCommitKey low for 2 cycles, high, then low 2 cycles (bounce) -> no action, Dest unchanged, FSM returns to IDLE.
- Both keys low on the same cycle with LoadValue=3, AluResult=7 -> Dest=7 (commit priority). Releasing commit while load is still held gives no load action until load is released and pressed again.
- nReset asserted at counter=2 in PRESS_DB, with Dest=5 beforehand -> Dest=0 immediately. Key still held after reset release -> action at edge 7 after release.
